// File: rtl/dma_periph_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dma_periph_pkg
// Description : Shared types and constants for the DMA peripheral responder.
//               It holds the FSM state bit indices and their one-hot codes,
//               the transfer direction type and the errStatus bit positions.
// Revision    : 1.0 - initial release
// ============================================================================
package dma_periph_pkg;

  // Bit position of each state inside the one-hot state vector.
  typedef enum logic [2:0] {
    ST_IDLE_IDX  = 3'd0,
    ST_REQ_IDX   = 3'd1,
    ST_XFER_IDX  = 3'd2,
    ST_RECOV_IDX = 3'd3,
    ST_TERM_IDX  = 3'd4
  } state_idx_e;

  localparam int NUM_STATES = 5;

  // One-hot state codes.
  localparam logic [4:0] ST_IDLE  = 5'b00001;
  localparam logic [4:0] ST_REQ   = 5'b00010;
  localparam logic [4:0] ST_XFER  = 5'b00100;
  localparam logic [4:0] ST_RECOV = 5'b01000;
  localparam logic [4:0] ST_TERM  = 5'b10000;

  // DIR_READ: the DMA reads the device (IOR_N path).
  typedef enum logic {
    DIR_WRITE = 1'b0,
    DIR_READ  = 1'b1
  } dir_e;

  // errStatus = {protoErr, overflow, underflow}
  localparam int ERR_UNDERFLOW = 0;
  localparam int ERR_OVERFLOW  = 1;
  localparam int ERR_PROTO     = 2;
  localparam int ERR_W         = 3;

endpackage
`default_nettype wire

// File: rtl/dma_peripheral_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : dma_peripheral_responder_if
// Description : DMA channel bus between the DMA timing-and-control block
//               (master) and the peripheral responder (slave).
//   DREQ    : request to the controller          (slave -> master)
//   DACK    : acknowledge, active-high           (master -> slave)
//   IOR_N   : I/O read strobe, active-low        (master -> slave)
//   IOW_N   : I/O write strobe, active-low       (master -> slave)
//   EOP_N   : terminal count, active-low         (master -> slave)
//   dbIn    : data bus sampled on IOW_N          (master -> slave)
//   dbOut   : data driven during IOR_N           (slave -> master)
//   dbOutEn : dbOut bus driver enable            (slave -> master)
// Revision    : 1.0 - initial release
// ============================================================================
interface dma_peripheral_responder_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  DREQ;
  logic                  DACK;
  logic                  IOR_N;
  logic                  IOW_N;
  logic                  EOP_N;
  logic [DATA_WIDTH-1:0] dbIn;
  logic [DATA_WIDTH-1:0] dbOut;
  logic                  dbOutEn;

  modport master (
    input  DREQ, dbOut, dbOutEn,
    output DACK, IOR_N, IOW_N, EOP_N, dbIn
  );

  modport slave (
    output DREQ, dbOut, dbOutEn,
    input  DACK, IOR_N, IOW_N, EOP_N, dbIn
  );
endinterface
`default_nettype wire

// File: rtl/dma_byte_fifo.sv
`default_nettype none
// ============================================================================
// Module      : dma_byte_fifo
// Description : Synchronous FIFO with valid/ready on both sides.
//   clk, rst        : clock, asynchronous active-high reset
//   i_push_*        : write side (valid/data in, ready out)
//   o_pop_*         : read side (valid/data out, ready in), data is the head
//   o_full/o_empty  : occupancy flags
//   o_count         : occupancy, clog2(FIFO_DEPTH)+1 bits
// A push is accepted while full if a pop happens in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module dma_byte_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  wire logic                           clk,
  input  wire logic                           rst,
  input  wire logic                           i_push_valid,
  input  wire logic [DATA_WIDTH-1:0]          i_push_data,
  output logic                                o_push_ready,
  output logic                                o_pop_valid,
  output logic [DATA_WIDTH-1:0]               o_pop_data,
  input  wire logic                           i_pop_ready,
  output logic                                o_full,
  output logic                                o_empty,
  output logic [$clog2(FIFO_DEPTH):0]         o_count
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_count;

  logic w_full;
  logic w_empty;
  logic w_pop;
  logic w_push;

  assign w_full  = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_empty = (r_count == '0);
  assign w_pop   = !w_empty && i_pop_ready;
  // A full FIFO still accepts when the head leaves in the same cycle.
  assign w_push  = i_push_valid && (!w_full || w_pop);

  assign o_push_ready = !w_full || w_pop;
  assign o_pop_valid  = !w_empty;
  assign o_pop_data   = r_mem[r_rd_ptr];
  assign o_full       = w_full;
  assign o_empty      = w_empty;
  assign o_count      = r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      // Power-of-two depth: pointers wrap naturally.
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is not reset; contents are discarded via the pointers.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_push_data;
  end
endmodule
`default_nettype wire

// File: rtl/dma_peripheral_responder.sv
`default_nettype none
// ============================================================================
// Module      : dma_peripheral_responder
// Description : Peripheral end of the DREQ/DACK/IOR_N/IOW_N DMA handshake.
//               It requests service when its byte FIFOs need it, answers one
//               single-mode transfer per request and pulses doneIrq on
//               terminal count.
//   CLK, RESET      : clock, asynchronous active-high reset
//   cfgEnable       : arm channel (rising edge re-arms after terminal count)
//   cfgDir          : 1 = DMA reads device, 0 = DMA writes device
//   bus             : DMA channel bus (slave modport)
//   devPush*        : device -> memory byte stream (into rdFifo)
//   devPop*         : memory -> device byte stream (out of wrFifo)
//   doneIrq         : one-cycle terminal count pulse
//   errStatus       : sticky {protoErr, overflow, underflow}
// Revision    : 1.0 - initial release
// ============================================================================
module dma_peripheral_responder
  import dma_periph_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  wire logic                  CLK,
  input  wire logic                  RESET,
  input  wire logic                  cfgEnable,
  input  wire logic                  cfgDir,
  dma_peripheral_responder_if.slave  bus,
  input  wire logic [DATA_WIDTH-1:0] devPushData,
  input  wire logic                  devPushValid,
  output logic                       devPushReady,
  output logic [DATA_WIDTH-1:0]      devPopData,
  output logic                       devPopValid,
  input  wire logic                  devPopReady,
  output logic                       doneIrq,
  output logic [ERR_W-1:0]           errStatus
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [4:0]            r_state;
  logic [4:0]            w_state_nxt;
  logic                  r_armed;
  logic                  r_cfg_en_d;
  dir_e                  r_dir;
  logic                  r_eop;
  logic                  r_in_stb;
  logic [DATA_WIDTH-1:0] r_dbout;
  logic [ERR_W-1:0]      r_err;

  logic                  w_ior;
  logic                  w_iow;
  logic                  w_eop;
  logic                  w_dack;
  logic                  w_sel;
  logic                  w_stb_any;
  logic                  w_first;
  logic                  w_proto;
  logic                  w_rd_stb;
  logic                  w_wr_stb;
  logic                  w_rd_pop_req;
  logic                  w_wr_push_req;
  logic                  w_underflow;
  logic                  w_overflow;
  dir_e                  w_dir;
  logic                  w_need;
  logic [DATA_WIDTH-1:0] w_head_or_zero;
  logic [DATA_WIDTH-1:0] w_dbval;

  logic                  w_rd_empty;
  logic                  w_rd_full;
  logic [CNT_W-1:0]      w_rd_count;
  logic [DATA_WIDTH-1:0] w_rd_head;
  logic                  w_rd_valid;
  logic                  w_wr_empty;
  logic                  w_wr_full;
  logic [CNT_W-1:0]      w_wr_count;
  logic                  w_wr_push_ready;

  // Only a solid 0 counts as an asserted low strobe; Z/X read as inactive.
  assign w_ior  = (bus.IOR_N === 1'b0);
  assign w_iow  = (bus.IOW_N === 1'b0);
  assign w_eop  = (bus.EOP_N === 1'b0);
  assign w_dack = (bus.DACK === 1'b1);

  // Direction is sampled live while idle and frozen for the rest of a cycle.
  assign w_dir = r_state[ST_IDLE_IDX] ? dir_e'(cfgDir) : r_dir;

  assign w_sel     = r_armed && w_dack;
  assign w_stb_any = w_sel && (w_ior || w_iow);
  assign w_first   = w_stb_any && !r_in_stb;
  assign w_proto   = w_sel && w_ior && w_iow;
  assign w_rd_stb  = w_sel && w_ior && !w_iow && (w_dir == DIR_READ);
  assign w_wr_stb  = w_sel && w_iow && !w_ior && (w_dir == DIR_WRITE);

  // Exactly one FIFO action per strobe, taken on its first low cycle.
  assign w_rd_pop_req  = w_first && w_rd_stb;
  assign w_wr_push_req = w_first && w_wr_stb;
  assign w_underflow   = w_rd_pop_req && w_rd_empty;
  assign w_overflow    = w_wr_push_req && !w_wr_push_ready;

  assign w_need = r_armed && ((w_dir == DIR_READ) ? !w_rd_empty : !w_wr_full);

  // On the first strobe cycle the head is not yet in r_dbout, so present it
  // straight from the FIFO; afterwards the held copy is driven.
  assign w_head_or_zero = w_rd_empty ? '0 : w_rd_head;
  assign w_dbval        = w_first ? w_head_or_zero : r_dbout;

  assign bus.DREQ    = r_state[ST_REQ_IDX];
  assign bus.dbOutEn = w_rd_stb;
  assign bus.dbOut   = w_rd_stb ? w_dbval : '0;
  assign doneIrq     = r_state[ST_TERM_IDX];
  assign errStatus   = r_err;

  dma_byte_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_rd_fifo (
    .clk          (CLK),
    .rst          (RESET),
    .i_push_valid (devPushValid),
    .i_push_data  (devPushData),
    .o_push_ready (devPushReady),
    .o_pop_valid  (w_rd_valid),
    .o_pop_data   (w_rd_head),
    .i_pop_ready  (w_rd_pop_req),
    .o_full       (w_rd_full),
    .o_empty      (w_rd_empty),
    .o_count      (w_rd_count)
  );

  dma_byte_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_wr_fifo (
    .clk          (CLK),
    .rst          (RESET),
    .i_push_valid (w_wr_push_req),
    .i_push_data  (bus.dbIn),
    .o_push_ready (w_wr_push_ready),
    .o_pop_valid  (devPopValid),
    .o_pop_data   (devPopData),
    .i_pop_ready  (devPopReady),
    .o_full       (w_wr_full),
    .o_empty      (w_wr_empty),
    .o_count      (w_wr_count)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_need) w_state_nxt = ST_REQ;
      ST_REQ: begin
        if (w_dack)       w_state_nxt = ST_XFER;
        else if (!w_need) w_state_nxt = ST_IDLE;
      end
      // Leave once the strobe has come and gone, or the controller lets go.
      ST_XFER:  if (!w_dack || (r_in_stb && !w_stb_any)) w_state_nxt = ST_RECOV;
      ST_RECOV: w_state_nxt = (r_eop || w_eop) ? ST_TERM : ST_IDLE;
      ST_TERM:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state    <= ST_IDLE;
      r_armed    <= 1'b0;
      r_cfg_en_d <= 1'b0;
      r_dir      <= DIR_WRITE;
      r_eop      <= 1'b0;
      r_in_stb   <= 1'b0;
      r_dbout    <= '0;
      r_err      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_cfg_en_d <= cfgEnable;
      r_in_stb   <= w_stb_any;

      if (r_state[ST_IDLE_IDX]) r_dir <= dir_e'(cfgDir);

      // A new rising edge wins over the terminal-count disarm.
      if (!cfgEnable)                    r_armed <= 1'b0;
      else if (!r_cfg_en_d)              r_armed <= 1'b1;
      else if (r_state[ST_TERM_IDX])     r_armed <= 1'b0;

      // EOP is remembered so the current strobe can finish first.
      if (r_state[ST_TERM_IDX])
        r_eop <= 1'b0;
      else if (w_eop && (r_state[ST_REQ_IDX] || r_state[ST_XFER_IDX] || r_state[ST_RECOV_IDX]))
        r_eop <= 1'b1;

      if (w_rd_pop_req) r_dbout <= w_head_or_zero;

      if (w_underflow) r_err[ERR_UNDERFLOW] <= 1'b1;
      if (w_overflow)  r_err[ERR_OVERFLOW]  <= 1'b1;
      if (w_proto)     r_err[ERR_PROTO]     <= 1'b1;
    end
  end

  a_state_onehot: assert property (@(posedge CLK) disable iff (RESET) $onehot(r_state));
  a_no_dreq_in_xfer: assert property (@(posedge CLK) disable iff (RESET)
    r_state[ST_XFER_IDX] |-> !bus.DREQ);
  a_one_op_per_strobe: assert property (@(posedge CLK) disable iff (RESET)
    (w_rd_pop_req || w_wr_push_req) |=> !(w_rd_pop_req || w_wr_push_req));
  a_done_single: assert property (@(posedge CLK) disable iff (RESET) doneIrq |=> !doneIrq);
  a_rd_count: assert property (@(posedge CLK) disable iff (RESET)
    (w_rd_count <= CNT_W'(FIFO_DEPTH)) && (w_rd_valid == !w_rd_empty) && !(w_rd_full && w_rd_empty));
  a_wr_count: assert property (@(posedge CLK) disable iff (RESET)
    (w_wr_count <= CNT_W'(FIFO_DEPTH)) && !(w_wr_full && w_wr_empty));
endmodule
`default_nettype wire
